pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage MIPS core. One instance serves as the D/E, E/M or M/W register. It carries NUM_CH data words plus PC, instruction, branch-delay flag and exception code. Beyond plain forwarding it supports:
- stall hold;
- bubble insertion that keeps PC/BD, so EPC stays correct;
- exception-request flush to the handler PC;
- first-exception-wins code merging;
- saturating stall and bubble performance counters.

Parameters:
DATA_W, 32, width of each data channel
NUM_CH, 5, number of data channels carried (V1, V2, EXT, PC8, misc)
EXC_W, 5, exception code width; 0 means no exception
CNT_W, 16, width of each performance counter
RESET_PC, 32'h0000_3000, out_pc value after reset
HANDLER_PC, 32'h0000_4180, out_pc value after an exception request

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
en  in  1  1 = advance; 0 = stall (hold contents)
flush  in  1  insert a bubble (hazard stall in the upstream stage)
req  in  1  exception/interrupt request; flush the whole register to the handler
in_data  in  NUM_CH*DATA_W  data channels; channel k at bits [k*DATA_W +: DATA_W]
in_pc  in  32  PC of the incoming instruction
in_instr  in  32  incoming instruction word
in_bd  in  1  incoming instruction is in a branch delay slot
in_exc  in  EXC_W  exception code inherited from earlier stages
det_exc  in  EXC_W  exception detected in the current (upstream) stage
in_valid  in  1  incoming slot holds a real instruction
out_data  out  NUM_CH*DATA_W  registered data channels
out_pc  out  32  registered PC
out_instr  out  32  registered instruction
out_bd  out  1  registered delay-slot flag
out_exc  out  EXC_W  registered, merged exception code
out_valid  out  1  registered valid flag
stall_cnt  out  CNT_W  count of cycles held while holding a valid instruction
bubble_cnt  out  CNT_W  count of bubbles inserted

Behaviour:
- All outputs are registered, updated on the rising edge of clk. Latency is 1 cycle from inputs to outputs when advancing.
- Update priority per edge is reset > req > flush > en > hold.
- reset:
  - out_data, out_instr, out_exc, out_bd, out_valid = 0.
  - out_pc = RESET_PC.
  - stall_cnt = 0 and bubble_cnt = 0.
- req (reset low):
  - out_data, out_instr, out_exc, out_bd, out_valid = 0.
  - out_pc = HANDLER_PC.
  - Counters unchanged.
  - req overrides flush and en.
- flush (reset and req low):
  - out_data, out_instr, out_exc = 0 and out_valid = 0.
  - out_pc = in_pc and out_bd = in_bd, so a bubble still reports the correct EPC/BD.
  - flush takes effect even when en = 0.
  - bubble_cnt increments by 1.
- en = 1, no flush/req/reset:
  - out_data, out_pc, out_instr, out_bd, out_valid load from the inputs.
  - out_exc = in_exc if in_exc != 0, else det_exc. An earlier-stage exception always wins.
- en = 0, no flush/req/reset:
  - All outputs hold.
  - stall_cnt increments only if out_valid = 1.
- Counters saturate at 2^CNT_W - 1, with no wrap. Only reset clears them.
- in_valid = 0 while advancing loads a bubble-like slot: fields are loaded as given and bubble_cnt is not incremented.
- Reset mid-stall or mid-flush: reset wins and the next cycle starts from reset values.
- No combinational path from any input to any output.

Test Plan:
- Reset sequence:
  - Stimulus: reset=1 for 2 cycles with random inputs.
  - Required: out_pc=0x3000; all other outputs and both counters are 0.
- Advance with exception merge:
  - Stimulus: en=1, in_pc=0x3010, in_instr=0x8C220004, ch0=0xDEADBEEF, in_exc=0, det_exc=4.
  - Required: next cycle shows the same values, out_exc=4, out_valid=1.
  - Follow-up stimulus: repeat with in_exc=12, det_exc=4.
  - Required: out_exc=12.
- Stall then flush:
  - Stimulus: load valid in_pc=0x3020, then en=0 for 3 cycles.
  - Required: outputs hold and stall_cnt=3.
  - Follow-up stimulus: flush=1 with in_pc=0x3024, in_bd=1.
  - Required: out_valid=0, out_instr=0, out_pc=0x3024, out_bd=1, bubble_cnt=1.
- Exception request overrides:
  - Stimulus: req=1, flush=1, en=1 simultaneously.
  - Required: out_pc=0x4180, all other fields 0, bubble_cnt unchanged.
- Counter saturation:
  - Stimulus: CNT_W=4 with a valid instruction stalled for 20 cycles.
  - Required: stall_cnt stops at 15.
  - Follow-up stimulus: reset.
  - Required: stall_cnt = 0.
- Channel packing:
  - Stimulus: NUM_CH=3, DATA_W=8, in_data=0x00A5C3.
  - Required: out_data=0x00A5C3 after 1 cycle; channel 1 = 0xA5.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core (D/E, E/M or M/W).
// It carries the data channels plus PC/instr/BD/exception state, with stall, bubble, flush and perf counters.
module pipe_stage_reg #(
  parameter int          DATA_W     = 32,
  parameter int          NUM_CH     = 5,
  parameter int          EXC_W      = 5,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     req,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_bd,
  input  logic [EXC_W-1:0]         in_exc,
  input  logic [EXC_W-1:0]         det_exc,
  input  logic                     in_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_bd,
  output logic [EXC_W-1:0]         out_exc,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [NUM_CH*DATA_W-1:0] data;
    logic [31:0]              pc;
    logic [31:0]              instr;
    logic                     bd;
    logic [EXC_W-1:0]         exc;
    logic                     valid;
  } slot_t;

  slot_t            slot_q, slot_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch;
  // here the default is "hold", which also covers the stall case.
  always_comb begin
    slot_d       = slot_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (req) begin
      slot_d    = '0;
      slot_d.pc = HANDLER_PC;
    end else if (flush) begin
      // The bubble keeps PC/BD so a later exception still reports the right EPC.
      slot_d       = '0;
      slot_d.pc    = in_pc;
      slot_d.bd    = in_bd;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else if (en) begin
      slot_d.data  = in_data;
      slot_d.pc    = in_pc;
      slot_d.instr = in_instr;
      slot_d.bd    = in_bd;
      slot_d.exc   = (in_exc != '0) ? in_exc : det_exc;
      slot_d.valid = in_valid;
    end else if (slot_q.valid) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their next-state values from the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= '0;
      slot_q.pc    <= RESET_PC;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      slot_q       <= slot_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_data   = slot_q.data;
  assign out_pc     = slot_q.pc;
  assign out_instr  = slot_q.instr;
  assign out_bd     = slot_q.bd;
  assign out_exc    = slot_q.exc;
  assign out_valid  = slot_q.valid;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default instance and a narrow one
// (NUM_CH=3, DATA_W=8, CNT_W=4) for channel packing and counter saturation.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic ok, input string got, input string want);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  // ---------------- instance A: default parameters ----------------
  logic         a_reset, a_en, a_flush, a_req, a_bd, a_valid;
  logic [159:0] a_data;
  logic [31:0]  a_pc, a_instr;
  logic [4:0]   a_exc, a_det;
  logic [159:0] ao_data;
  logic [31:0]  ao_pc, ao_instr;
  logic         ao_bd, ao_valid;
  logic [4:0]   ao_exc;
  logic [15:0]  ao_stall, ao_bubble;

  pipe_stage_reg dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .flush(a_flush), .req(a_req),
    .in_data(a_data), .in_pc(a_pc), .in_instr(a_instr), .in_bd(a_bd),
    .in_exc(a_exc), .det_exc(a_det), .in_valid(a_valid),
    .out_data(ao_data), .out_pc(ao_pc), .out_instr(ao_instr), .out_bd(ao_bd),
    .out_exc(ao_exc), .out_valid(ao_valid), .stall_cnt(ao_stall), .bubble_cnt(ao_bubble)
  );

  // ---------------- instance B: narrow channels, 4-bit counters ----------------
  logic        b_reset, b_en, b_flush, b_req, b_bd, b_valid;
  logic [23:0] b_data;
  logic [31:0] b_pc, b_instr;
  logic [4:0]  b_exc, b_det;
  logic [23:0] bo_data;
  logic [31:0] bo_pc, bo_instr;
  logic        bo_bd, bo_valid;
  logic [4:0]  bo_exc;
  logic [3:0]  bo_stall, bo_bubble;

  pipe_stage_reg #(.DATA_W(8), .NUM_CH(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .flush(b_flush), .req(b_req),
    .in_data(b_data), .in_pc(b_pc), .in_instr(b_instr), .in_bd(b_bd),
    .in_exc(b_exc), .det_exc(b_det), .in_valid(b_valid),
    .out_data(bo_data), .out_pc(bo_pc), .out_instr(bo_instr), .out_bd(bo_bd),
    .out_exc(bo_exc), .out_valid(bo_valid), .stall_cnt(bo_stall), .bubble_cnt(bo_bubble)
  );

  // ---------------- scoreboards ----------------
  typedef struct {
    int           tag;
    string        name;
    logic [159:0] data;
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic         bd;
    logic [4:0]   exc;
    logic         valid;
    logic [15:0]  stall;
    logic [15:0]  bubble;
  } exp_a_t;

  typedef struct {
    int          tag;
    string       name;
    logic [23:0] data;
    logic [31:0] pc;
    logic        valid;
    logic [3:0]  stall;
    logic [3:0]  bubble;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  // Expectations are tagged with the edge after which they must hold.
  task automatic push_a(input string name, input logic [159:0] data, input logic [31:0] pc,
                        input logic [31:0] instr, input logic bd, input logic [4:0] exc,
                        input logic valid, input logic [15:0] stall, input logic [15:0] bubble);
    exp_a_t e;
    e.tag = edges + 1; e.name = name; e.data = data; e.pc = pc; e.instr = instr;
    e.bd = bd; e.exc = exc; e.valid = valid; e.stall = stall; e.bubble = bubble;
    qa.push_back(e);
  endtask

  task automatic push_b(input string name, input logic [23:0] data, input logic [31:0] pc,
                        input logic valid, input logic [3:0] stall, input logic [3:0] bubble);
    exp_b_t e;
    e.tag = edges + 1; e.name = name; e.data = data; e.pc = pc;
    e.valid = valid; e.stall = stall; e.bubble = bubble;
    qb.push_back(e);
  endtask

  exp_a_t ea;
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].tag <= edges) begin
      ea = qa.pop_front();
      check(ea.name,
            ea.tag == edges && ao_data === ea.data && ao_pc === ea.pc && ao_instr === ea.instr &&
            ao_bd === ea.bd && ao_exc === ea.exc && ao_valid === ea.valid &&
            ao_stall === ea.stall && ao_bubble === ea.bubble,
            $sformatf("edge=%0d data=%h pc=%h instr=%h bd=%b exc=%0d v=%b stall=%0d bub=%0d",
                      edges, ao_data, ao_pc, ao_instr, ao_bd, ao_exc, ao_valid, ao_stall, ao_bubble),
            $sformatf("edge=%0d data=%h pc=%h instr=%h bd=%b exc=%0d v=%b stall=%0d bub=%0d",
                      ea.tag, ea.data, ea.pc, ea.instr, ea.bd, ea.exc, ea.valid, ea.stall, ea.bubble));
    end
  end

  exp_b_t eb;
  always @(negedge clk) begin
    while (qb.size() > 0 && qb[0].tag <= edges) begin
      eb = qb.pop_front();
      check(eb.name,
            eb.tag == edges && bo_data === eb.data && bo_pc === eb.pc && bo_valid === eb.valid &&
            bo_stall === eb.stall && bo_bubble === eb.bubble,
            $sformatf("edge=%0d data=%h pc=%h v=%b stall=%0d bub=%0d",
                      edges, bo_data, bo_pc, bo_valid, bo_stall, bo_bubble),
            $sformatf("edge=%0d data=%h pc=%h v=%b stall=%0d bub=%0d",
                      eb.tag, eb.data, eb.pc, eb.valid, eb.stall, eb.bubble));
      if (eb.tag == edges)
        check({eb.name, "_ch1"}, bo_data[15:8] === eb.data[15:8],
              $sformatf("%h", bo_data[15:8]), $sformatf("%h", eb.data[15:8]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [159:0] D_ADV = {32'h5, 32'h4, 32'h3, 32'h2, 32'hDEAD_BEEF};
  localparam logic [159:0] D_STL = {32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678};

  initial begin
    {a_en, a_flush, a_req, a_bd, a_valid} = '0;
    a_data = '0; a_pc = '0; a_instr = '0; a_exc = '0; a_det = '0;
    {b_en, b_flush, b_req, b_bd, b_valid} = '0;
    b_data = '0; b_pc = '0; b_instr = '0; b_exc = '0; b_det = '0;
    a_reset = 1'b1;
    b_reset = 1'b1;

    // Reset for two cycles with random inputs on A.
    for (int i = 0; i < 2; i++) begin
      a_en = 1'($urandom); a_flush = 1'($urandom); a_req = 1'($urandom);
      a_data = {5{$urandom}}; a_pc = $urandom; a_instr = $urandom;
      a_bd = 1'($urandom); a_exc = 5'($urandom); a_det = 5'($urandom); a_valid = 1'($urandom);
      push_a("reset", '0, 32'h3000, '0, 1'b0, '0, 1'b0, 16'd0, 16'd0);
      push_b("reset_b", '0, 32'h3000, 1'b0, 4'd0, 4'd0);
      tick();
    end
    a_reset = 1'b0;
    b_reset = 1'b0;
    {a_en, a_flush, a_req, a_bd, a_valid} = '0;

    // Advance with exception merge: detected code used when inherited is 0.
    a_en = 1'b1; a_valid = 1'b1; a_pc = 32'h3010; a_instr = 32'h8C22_0004;
    a_data = D_ADV; a_exc = 5'd0; a_det = 5'd4;
    push_a("adv_det_exc", D_ADV, 32'h3010, 32'h8C22_0004, 1'b0, 5'd4, 1'b1, 16'd0, 16'd0);
    tick();
    a_exc = 5'd12;
    push_a("adv_in_exc_wins", D_ADV, 32'h3010, 32'h8C22_0004, 1'b0, 5'd12, 1'b1, 16'd0, 16'd0);
    tick();

    // Load a valid instruction, then stall three cycles while inputs change.
    a_pc = 32'h3020; a_instr = 32'h0000_0020; a_data = D_STL; a_exc = 5'd0; a_det = 5'd0;
    push_a("load_3020", D_STL, 32'h3020, 32'h0000_0020, 1'b0, 5'd0, 1'b1, 16'd0, 16'd0);
    tick();
    a_en = 1'b0; a_pc = 32'hFFFF_0000; a_instr = 32'hFFFF_FFFF; a_data = '1; a_exc = 5'd7;
    for (int i = 1; i <= 3; i++) begin
      push_a($sformatf("stall_hold_%0d", i), D_STL, 32'h3020, 32'h0000_0020, 1'b0, 5'd0, 1'b1,
             16'(i), 16'd0);
      tick();
    end

    // Flush with en=0: bubble keeps PC/BD, clears the rest.
    a_flush = 1'b1; a_pc = 32'h3024; a_bd = 1'b1;
    push_a("flush_bubble", '0, 32'h3024, '0, 1'b1, '0, 1'b0, 16'd3, 16'd1);
    tick();

    // Exception request overrides flush and en.
    a_req = 1'b1; a_en = 1'b1; a_pc = 32'h5000;
    push_a("req_override", '0, 32'h4180, '0, 1'b0, '0, 1'b0, 16'd3, 16'd1);
    tick();
    a_req = 1'b0; a_flush = 1'b0; a_en = 1'b0; a_bd = 1'b0;

    // Stalling an invalid slot does not count.
    push_a("stall_invalid", '0, 32'h4180, '0, 1'b0, '0, 1'b0, 16'd3, 16'd1);
    tick();

    // Advancing with in_valid=0 loads fields as given, no bubble counted.
    a_en = 1'b1; a_valid = 1'b0; a_pc = 32'h3030; a_instr = 32'h0000_1234;
    a_data = 160'hAA; a_exc = 5'd0; a_det = 5'd0;
    push_a("adv_invalid", 160'hAA, 32'h3030, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 16'd3, 16'd1);
    tick();

    // Reset during a stall wins and clears counters.
    a_en = 1'b0; a_reset = 1'b1;
    push_a("reset_mid_stall", '0, 32'h3000, '0, 1'b0, '0, 1'b0, 16'd0, 16'd0);
    tick();
    a_reset = 1'b0;

    // Instance B: channel packing, then saturation of the 4-bit stall counter.
    b_en = 1'b1; b_valid = 1'b1; b_pc = 32'h3040; b_data = 24'h00A5C3;
    push_b("pack_3ch", 24'h00A5C3, 32'h3040, 1'b1, 4'd0, 4'd0);
    tick();
    b_en = 1'b0; b_data = 24'hFFFFFF;
    for (int i = 1; i <= 20; i++) begin
      push_b($sformatf("sat_stall_%0d", i), 24'h00A5C3, 32'h3040, 1'b1,
             (i > 15) ? 4'd15 : 4'(i), 4'd0);
      tick();
    end
    b_reset = 1'b1;
    push_b("sat_reset", '0, 32'h3000, 1'b0, 4'd0, 4'd0);
    tick();
    b_reset = 1'b0;

    // Bounded drain; anything still queued was never observed.
    repeat (4) tick();
    while (qa.size() > 0) begin
      ea = qa.pop_front();
      check({ea.name, "_timeout"}, 1'b0, "not observed", $sformatf("edge %0d", ea.tag));
    end
    while (qb.size() > 0) begin
      eb = qb.pop_front();
      check({eb.name, "_timeout"}, 1'b0, "not observed", $sformatf("edge %0d", eb.tag));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
